sirv_tl_fragment_seq: RTL and testbench



---
 rtl/sirv_tl_fragment_seq_if.sv | 16 +
 rtl/sirv_tl_fragment_seq.sv | 66 ++++++
 tb/tb_sirv_tl_fragment_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sirv_tl_fragment_seq_if.sv
// sirv_tl_fragment_seq_if: one TileLink-UL A-channel beat with valid/ready handshake
interface sirv_tl_fragment_seq_if #(
    parameter int ADDR_W = 30
);
    logic              valid;
    logic              ready;
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [2:0]        size;
    logic [1:0]        source;
    logic [ADDR_W-1:0] address;
    logic              mask;
    logic [7:0]        data;
    modport master (output valid, opcode, param, size, source, address, mask, data, input ready);
    modport slave  (input valid, opcode, param, size, source, address, mask, data, output ready);
endinterface

// File: rtl/sirv_tl_fragment_seq.sv
// sirv_tl_fragment_seq: splits multi-byte TL-UL A requests into byte fragments; define SIRV_FRAG_SEQ_ERR_EN to add the sticky err output
module sirv_tl_fragment_seq #(
    parameter int MAX_SIZE = 2,
    parameter int ADDR_W   = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    sirv_tl_fragment_seq_if.slave  in_a,
    sirv_tl_fragment_seq_if.master out_a,
    output logic                  repeat_req,
    output logic                  busy
`ifdef SIRV_FRAG_SEQ_ERR_EN
    ,
    output logic                  err
`endif
);
    logic [MAX_SIZE-1:0] cnt_q, cnt_d, emask;
    logic [2:0]          esize;
    logic                is_put, last, fire;

    // fragment index bookkeeping: clamp size, find the final fragment, advance on fire
    always_comb begin
        esize  = (in_a.size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : in_a.size;
        emask  = ~({MAX_SIZE{1'b1}} << esize);
        is_put = in_a.opcode[2:1] == 2'b00;
        last   = (esize == 3'd0) || (cnt_q == emask);
        fire   = in_a.valid & out_a.ready;
        cnt_d  = fire ? (last ? '0 : cnt_q + MAX_SIZE'(1)) : cnt_q;
    end

    // fragment counter, cleared asynchronously so a reset restarts at the first byte
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign out_a.valid   = in_a.valid;
    assign in_a.ready    = out_a.ready;
    assign out_a.opcode  = in_a.opcode;
    assign out_a.param   = in_a.param;
    assign out_a.size    = 3'd0;
    assign out_a.source  = in_a.source;
    assign out_a.address = {in_a.address[ADDR_W-1:MAX_SIZE], in_a.address[MAX_SIZE-1:0] | (cnt_q & emask)};
    assign out_a.mask    = is_put ? in_a.mask : 1'b1;
    assign out_a.data    = in_a.data;
    assign repeat_req    = in_a.valid & ~is_put & ~last & ~reset;
    assign busy          = cnt_q != '0;

`ifdef SIRV_FRAG_SEQ_ERR_EN
    logic err_q, err_d;

    // flag oversize or misaligned requests when their first fragment is accepted
    always_comb begin
        err_d = err_q | (fire && cnt_q == '0 &&
                ((in_a.size > 3'(MAX_SIZE)) || ((in_a.address[MAX_SIZE-1:0] & emask) != '0)));
    end

    // sticky error flag, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_sirv_tl_fragment_seq.sv
// tb_sirv_tl_fragment_seq: directed and randomized requests checked against a per-request byte-index model
module tb_sirv_tl_fragment_seq;
    localparam int ADDR_W = 30;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic repeat_req, busy;
`ifdef SIRV_FRAG_SEQ_ERR_EN
    logic err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;   // model: index of the next byte within the current request
    bit err_m = 0;   // model: sticky error

    sirv_tl_fragment_seq_if #(.ADDR_W(ADDR_W)) in_a ();
    sirv_tl_fragment_seq_if #(.ADDR_W(ADDR_W)) out_a ();

    sirv_tl_fragment_seq #(.MAX_SIZE(2), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_a       (in_a),
        .out_a      (out_a),
        .repeat_req (repeat_req),
        .busy       (busy)
`ifdef SIRV_FRAG_SEQ_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // drive one cycle from a negedge, check outputs, advance the model on an accepted beat
    task automatic beat(input logic [2:0] op, input logic [2:0] sz, input logic [ADDR_W-1:0] addr,
                        input logic v, input logic rdy, output logic fired);
        int nf;
        bit put, lst;
        logic [7:0] d;
        logic m;
        logic [2:0] prm;
        logic [1:0] src;
        d = 8'($urandom); m = 1'($urandom); prm = 3'($urandom); src = 2'($urandom);
        in_a.valid = v; in_a.opcode = op; in_a.size = sz; in_a.address = addr;
        in_a.param = prm; in_a.source = src; in_a.mask = m; in_a.data = d;
        out_a.ready = rdy;
        #1;
        nf  = 1 << ((sz > 3'd2) ? 2 : int'(sz));
        put = op < 3'd2;
        lst = (k == nf - 1);
        check("out_valid", 32'(out_a.valid), 32'(v));
        check("in_ready", 32'(in_a.ready), 32'(rdy));
        check("out_size", 32'(out_a.size), 32'd0);
        check("out_opcode", 32'(out_a.opcode), 32'(op));
        check("out_param", 32'(out_a.param), 32'(prm));
        check("out_source", 32'(out_a.source), 32'(src));
        check("out_data", 32'(out_a.data), 32'(d));
        check("out_mask", 32'(out_a.mask), put ? 32'(m) : 32'd1);
        check("out_address", 32'(out_a.address), 32'(ADDR_W'(addr + ADDR_W'(k))));
        check("repeat", 32'(repeat_req), 32'(v && !put && !lst));
        check("busy", 32'(busy), 32'(k != 0));
`ifdef SIRV_FRAG_SEQ_ERR_EN
        check("err", 32'(err), 32'(err_m));
`endif
        fired = v & rdy;
        @(posedge clock);
        if (fired) begin
            if (k == 0 && (sz > 3'd2 || (int'(addr) % nf) != 0)) err_m = 1;
            k = lst ? 0 : k + 1;
        end
        @(negedge clock);
    endtask

    // issue a whole request: Puts need one beat per byte, others one fire per (clamped) fragment
    task automatic req(input logic [2:0] op, input logic [2:0] sz, input logic [ADDR_W-1:0] addr,
                       input int stall_pct, input int idle_pct);
        int need, got, guard;
        logic f, v, rdy;
        need  = (op < 3'd2) ? (1 << sz) : (1 << ((sz > 3'd2) ? 2 : int'(sz)));
        got   = 0;
        guard = 0;
        while (got < need && guard < 400) begin
            v   = ($urandom_range(99) >= idle_pct);
            rdy = ($urandom_range(99) >= stall_pct);
            beat(op, sz, addr, v, rdy, f);
            if (f) got++;
            guard++;
        end
        check("req_done", 32'(got), 32'(need));
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        k = 0;
        err_m = 0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_repeat", 32'(repeat_req), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic f;
        logic [2:0] op, sz;
        logic [ADDR_W-1:0] addr;
        // reset state with a live request presented
        in_a.valid = 1'b1; in_a.opcode = 3'd4; in_a.size = 3'd2; in_a.address = 30'h100;
        in_a.param = 0; in_a.source = 0; in_a.mask = 0; in_a.data = 0;
        out_a.ready = 1'b1;
        #1;
        check("rst_repeat", 32'(repeat_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_a.valid), 32'd1);
        check("rst_in_ready", 32'(in_a.ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        // Get size 2 at 0x100, no back-pressure
        req(3'd4, 3'd2, 30'h100, 0, 0);
        check("get4_busy_after", 32'(busy), 32'd0);
        // PutFull size 1 at 0x2A2
        req(3'd0, 3'd1, 30'h2A2, 0, 0);
        check("put2_busy_after", 32'(busy), 32'd0);
        // Get size 2 stalled for three cycles after the first fragment
        beat(3'd4, 3'd2, 30'h100, 1'b1, 1'b1, f);
        for (int i = 0; i < 3; i++) beat(3'd4, 3'd2, 30'h100, 1'b1, 1'b0, f);
        check("stall_addr", 32'(out_a.address), 32'h101);
        for (int i = 0; i < 3; i++) beat(3'd4, 3'd2, 30'h100, 1'b1, 1'b1, f);
        check("stall_done_busy", 32'(busy), 32'd0);
        // Get size 0 at 0x7
        req(3'd4, 3'd0, 30'h7, 0, 0);
        // reset after two fragments of a size-2 Get, then a fresh Get at 0x40
        beat(3'd4, 3'd2, 30'h200, 1'b1, 1'b1, f);
        beat(3'd4, 3'd2, 30'h200, 1'b1, 1'b1, f);
        check("mid_busy", 32'(busy), 32'd1);
        out_a.ready = 1'b0;
        #2;
        reset_pulse();
        req(3'd4, 3'd2, 30'h40, 0, 0);
        // oversize Get is clamped to four fragments
        req(3'd4, 3'd3, 30'h80, 0, 0);
`ifdef SIRV_FRAG_SEQ_ERR_EN
        check("err_sticky", 32'(err), 32'd1);
`endif
        reset_pulse();
        req(3'd4, 3'd1, 30'h10, 0, 0);
`ifdef SIRV_FRAG_SEQ_ERR_EN
        check("err_clean", 32'(err), 32'd0);
`endif

        // randomized aligned requests with stalls and idle beats
        for (int r = 0; r < 150; r++) begin
            case ($urandom_range(5))
                0: op = 3'd0; 1: op = 3'd1; 2: op = 3'd2;
                3: op = 3'd3; 4: op = 3'd4; default: op = 3'd5;
            endcase
            sz   = 3'($urandom_range(3));
            addr = ADDR_W'($urandom) & ~ADDR_W'((1 << sz) - 1);
            for (int i = $urandom_range(2); i > 0; i--) beat(op, sz, addr, 1'b0, 1'($urandom), f);
            req(op, sz, addr, 30, 10);
            if ($urandom_range(19) == 0) reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
